// File: rtl/rs_dispatch_queue_pkg.sv
// Shared types and widths for the reservation-station dispatch path.
// Operands carry a ready flag in the top bit above 64 data bits.
package rs_pkg;

    localparam int unsigned OPERAND_W = 65;
    localparam int unsigned READY_BIT = 64;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned CMD_W     = 10;
    localparam int unsigned ROB_SIZE  = 16;
    localparam int unsigned ROB_TAG_W = $clog2(ROB_SIZE + 1);

    typedef struct packed {
        logic              ready;
        logic [DATA_W-1:0] data;
    } rs_operand_t;

    typedef struct packed {
        logic [2:0][ROB_TAG_W-1:0] src_tag;
        rs_operand_t [2:0]         src_val;
        logic [ROB_TAG_W-1:0]      dst_tag;
        logic [CMD_W-1:0]          commands;
    } rs_dispatch_entry_t;

endpackage

// File: rtl/rs_dispatch_queue_if.sv
// Decode/cluster-facing signal bundle of rs_dispatch_queue.
// slave: the queue itself; master: decode, broadcast buses and cluster.
interface rs_dispatch_queue_if #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned CNT_W = 3
);
    import rs_pkg::*;

    logic                 needToRestore_i;
    logic                 enq_i;
    logic [TAG_W-1:0]     enqTag1_i, enqTag2_i, enqTag3_i, enqTag_i;
    logic [OPERAND_W-1:0] enqVal1_i, enqVal2_i, enqVal3_i;
    logic [CMD_W-1:0]     enqCommands_i;
    logic                 full_o;
    logic [TAG_W-1:0]     issueROBTagCom_i, issueROBTagExec_i, issueROBTagMem_i;
    logic [OPERAND_W-1:0] issueROBvalCom_i, issueROBvalExec_i, issueROBvalMem_i;
    logic                 issueROBMemAccessExec_i;
    logic                 rsStall_i;
    logic                 decodeWriteEn_o;
    logic [TAG_W-1:0]     decodeROBTag1_o, decodeROBTag2_o, decodeROBTag3_o, decodeROBTag_o;
    logic [OPERAND_W-1:0] decodeROBval1_o, decodeROBval2_o, decodeROBval3_o;
    logic [CMD_W-1:0]     decodeCommands_o;
    logic [CNT_W-1:0]     count_o;

    modport slave (
        input  needToRestore_i, enq_i, enqTag1_i, enqTag2_i, enqTag3_i, enqTag_i,
               enqVal1_i, enqVal2_i, enqVal3_i, enqCommands_i,
               issueROBTagCom_i, issueROBvalCom_i, issueROBTagExec_i, issueROBvalExec_i,
               issueROBMemAccessExec_i, issueROBTagMem_i, issueROBvalMem_i, rsStall_i,
        output full_o, decodeWriteEn_o, decodeROBTag1_o, decodeROBTag2_o, decodeROBTag3_o,
               decodeROBTag_o, decodeROBval1_o, decodeROBval2_o, decodeROBval3_o,
               decodeCommands_o, count_o
    );

    modport master (
        output needToRestore_i, enq_i, enqTag1_i, enqTag2_i, enqTag3_i, enqTag_i,
               enqVal1_i, enqVal2_i, enqVal3_i, enqCommands_i,
               issueROBTagCom_i, issueROBvalCom_i, issueROBTagExec_i, issueROBvalExec_i,
               issueROBMemAccessExec_i, issueROBTagMem_i, issueROBvalMem_i, rsStall_i,
        input  full_o, decodeWriteEn_o, decodeROBTag1_o, decodeROBTag2_o, decodeROBTag3_o,
               decodeROBTag_o, decodeROBval1_o, decodeROBval2_o, decodeROBval3_o,
               decodeCommands_o, count_o
    );

endinterface

// File: rtl/rs_dispatch_queue_snoop.sv
// rs_operand_snoop: combinational result-bus capture for one waiting operand.
// Priority commit > mem > exec; exec results that are addresses never forward.
module rs_operand_snoop
    import rs_pkg::*;
#(
    parameter int unsigned TAG_W = ROB_TAG_W
) (
    input  logic [TAG_W-1:0]     tag,
    input  rs_operand_t          operand,
    input  logic [TAG_W-1:0]     com_tag,
    input  logic [OPERAND_W-1:0] com_val,
    input  logic [TAG_W-1:0]     exec_tag,
    input  logic [OPERAND_W-1:0] exec_val,
    input  logic                 exec_is_addr,
    input  logic [TAG_W-1:0]     mem_tag,
    input  logic [OPERAND_W-1:0] mem_val,
    output rs_operand_t          snooped
);

    // A ready operand is left alone; otherwise take the highest-priority matching bus
    always_comb begin
        snooped = operand;
        if (!operand.ready) begin
            if (com_val[READY_BIT] && com_tag == tag) begin
                snooped = rs_operand_t'(com_val);
            end else if (mem_val[READY_BIT] && mem_tag == tag) begin
                snooped = rs_operand_t'(mem_val);
            end else if (exec_val[READY_BIT] && !exec_is_addr && exec_tag == tag) begin
                snooped = rs_operand_t'(exec_val);
            end
        end
    end

endmodule

// File: rtl/rs_dispatch_queue.sv
// rs_dispatch_queue: decode-side FIFO feeding the forwarding RS cluster.
// Queued operands keep snooping result buses so nothing is missed while the
// cluster stalls. Optional macro RS_DISPATCH_BYPASS_EN: an enqueue into an
// empty, unstalled queue is handed to the cluster in the same cycle.
module rs_dispatch_queue
    import rs_pkg::*;
#(
    parameter int unsigned ROBsize    = ROB_SIZE,
    parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1),
    parameter int unsigned DEPTH      = 4
) (
    input logic            clk_i,
    input logic            reset_i,
    rs_dispatch_queue_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rs_dispatch_entry_t    store_q [DEPTH];
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      count_q;

    logic [ROBsizeLog-1:0] in_tag [3];
    rs_operand_t           in_val [3];
    rs_operand_t           in_val_snp [3];
    rs_operand_t           head_val_snp [3];
    rs_operand_t           store_val_snp [DEPTH][3];
    rs_dispatch_entry_t    head_e, in_e;
    logic                  full, deq, enq_acc, bypass;

    assign in_tag[0] = bus.enqTag1_i;
    assign in_tag[1] = bus.enqTag2_i;
    assign in_tag[2] = bus.enqTag3_i;
    assign in_val[0] = bus.enqVal1_i;
    assign in_val[1] = bus.enqVal2_i;
    assign in_val[2] = bus.enqVal3_i;
    assign head_e    = store_q[head_q];

    for (genvar k = 0; k < 3; k++) begin : g_port
        rs_operand_snoop #(.TAG_W(ROBsizeLog)) u_in (
            .tag(in_tag[k]), .operand(in_val[k]),
            .com_tag(bus.issueROBTagCom_i), .com_val(bus.issueROBvalCom_i),
            .exec_tag(bus.issueROBTagExec_i), .exec_val(bus.issueROBvalExec_i),
            .exec_is_addr(bus.issueROBMemAccessExec_i),
            .mem_tag(bus.issueROBTagMem_i), .mem_val(bus.issueROBvalMem_i),
            .snooped(in_val_snp[k])
        );
        rs_operand_snoop #(.TAG_W(ROBsizeLog)) u_head (
            .tag(ROBsizeLog'(head_e.src_tag[k])), .operand(head_e.src_val[k]),
            .com_tag(bus.issueROBTagCom_i), .com_val(bus.issueROBvalCom_i),
            .exec_tag(bus.issueROBTagExec_i), .exec_val(bus.issueROBvalExec_i),
            .exec_is_addr(bus.issueROBMemAccessExec_i),
            .mem_tag(bus.issueROBTagMem_i), .mem_val(bus.issueROBvalMem_i),
            .snooped(head_val_snp[k])
        );
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        for (genvar k = 0; k < 3; k++) begin : g_opnd
            rs_operand_snoop #(.TAG_W(ROBsizeLog)) u_store (
                .tag(ROBsizeLog'(store_q[i].src_tag[k])), .operand(store_q[i].src_val[k]),
                .com_tag(bus.issueROBTagCom_i), .com_val(bus.issueROBvalCom_i),
                .exec_tag(bus.issueROBTagExec_i), .exec_val(bus.issueROBvalExec_i),
                .exec_is_addr(bus.issueROBMemAccessExec_i),
                .mem_tag(bus.issueROBTagMem_i), .mem_val(bus.issueROBvalMem_i),
                .snooped(store_val_snp[i][k])
            );
        end
    end

`ifdef RS_DISPATCH_BYPASS_EN
    assign bypass = (count_q == '0) & bus.enq_i & ~bus.rsStall_i & ~bus.needToRestore_i;
`else
    assign bypass = 1'b0;
`endif

    assign full    = (count_q == CNT_W'(DEPTH));
    assign deq     = (count_q != '0) & ~bus.rsStall_i & ~bus.needToRestore_i;
    // A bypassed instruction goes straight to the cluster and is never stored
    assign enq_acc = bus.enq_i & ~full & ~bus.needToRestore_i & ~bypass;

    assign bus.full_o          = full;
    assign bus.decodeWriteEn_o = deq | bypass;
    assign bus.count_o         = count_q;

    // Incoming instruction with same-cycle broadcasts already applied
    always_comb begin
        in_e = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            in_e.src_tag[k] = ROB_TAG_W'(in_tag[k]);
            in_e.src_val[k] = in_val_snp[k];
        end
        in_e.dst_tag  = ROB_TAG_W'(bus.enqTag_i);
        in_e.commands = bus.enqCommands_i;
    end

    // Cluster write port: snooped head entry, or the incoming one when bypassing
    always_comb begin
        bus.decodeROBTag1_o  = ROBsizeLog'(head_e.src_tag[0]);
        bus.decodeROBTag2_o  = ROBsizeLog'(head_e.src_tag[1]);
        bus.decodeROBTag3_o  = ROBsizeLog'(head_e.src_tag[2]);
        bus.decodeROBTag_o   = ROBsizeLog'(head_e.dst_tag);
        bus.decodeROBval1_o  = head_val_snp[0];
        bus.decodeROBval2_o  = head_val_snp[1];
        bus.decodeROBval3_o  = head_val_snp[2];
        bus.decodeCommands_o = head_e.commands;
        if (bypass) begin
            bus.decodeROBTag1_o  = in_tag[0];
            bus.decodeROBTag2_o  = in_tag[1];
            bus.decodeROBTag3_o  = in_tag[2];
            bus.decodeROBTag_o   = bus.enqTag_i;
            bus.decodeROBval1_o  = in_val_snp[0];
            bus.decodeROBval2_o  = in_val_snp[1];
            bus.decodeROBval3_o  = in_val_snp[2];
            bus.decodeCommands_o = bus.enqCommands_i;
        end
    end

    // FIFO state: flush on reset/restore, otherwise snoop all entries and push/pop
    always_ff @(posedge clk_i) begin
        if (reset_i || bus.needToRestore_i) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                for (int unsigned k = 0; k < 3; k++) begin
                    store_q[i].src_val[k] <= store_val_snp[i][k];
                end
            end
            if (enq_acc) begin
                store_q[tail_q] <= in_e;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({enq_acc, deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_dispatch_queue.sv
// Scoreboard bench for rs_dispatch_queue: the stimulus process keeps a queue of
// expected instructions (snooped every cycle by the broadcast rule), and a
// monitor pops and compares whenever the queue hands an entry to the cluster.
module tb_rs_dispatch_queue;
    import rs_pkg::*;

    typedef struct {
        logic [4:0]  t1, t2, t3, td;
        logic [64:0] v1, v2, v3;
        logic [9:0]  cmd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs_dispatch_queue_if #(.TAG_W(5), .CNT_W(3)) bus ();

    rs_dispatch_queue #(.ROBsize(16), .ROBsizeLog(5), .DEPTH(4)) dut (
        .clk_i(clk), .reset_i(rst), .bus(bus)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   model_count = 0;
    bit   mon_en = 1'b0;

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Broadcast capture rule applied to one waiting operand
    function automatic logic [64:0] snoop(logic [4:0] tag, logic [64:0] v);
        if (v[64]) return v;
        if (bus.issueROBvalCom_i[64] && bus.issueROBTagCom_i == tag) return bus.issueROBvalCom_i;
        if (bus.issueROBvalMem_i[64] && bus.issueROBTagMem_i == tag) return bus.issueROBvalMem_i;
        if (bus.issueROBvalExec_i[64] && !bus.issueROBMemAccessExec_i &&
            bus.issueROBTagExec_i == tag) return bus.issueROBvalExec_i;
        return v;
    endfunction

    function automatic exp_t incoming();
        exp_t e;
        e.t1  = bus.enqTag1_i;
        e.t2  = bus.enqTag2_i;
        e.t3  = bus.enqTag3_i;
        e.td  = bus.enqTag_i;
        e.v1  = snoop(e.t1, bus.enqVal1_i);
        e.v2  = snoop(e.t2, bus.enqVal2_i);
        e.v3  = snoop(e.t3, bus.enqVal3_i);
        e.cmd = bus.enqCommands_i;
        return e;
    endfunction

    function automatic logic [4:0] rtag();
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [64:0] rval();
        return {1'($urandom_range(0, 1)), $urandom(), $urandom()};
    endfunction

    task automatic idle();
        bus.needToRestore_i = 1'b0;
        bus.enq_i = 1'b0;
        bus.enqTag1_i = '0; bus.enqTag2_i = '0; bus.enqTag3_i = '0; bus.enqTag_i = '0;
        bus.enqVal1_i = '0; bus.enqVal2_i = '0; bus.enqVal3_i = '0;
        bus.enqCommands_i = '0;
        bus.issueROBTagCom_i = '0;  bus.issueROBvalCom_i = '0;
        bus.issueROBTagExec_i = '0; bus.issueROBvalExec_i = '0;
        bus.issueROBTagMem_i = '0;  bus.issueROBvalMem_i = '0;
        bus.issueROBMemAccessExec_i = 1'b0;
    endtask

    task automatic set_enq();
        bus.enq_i = 1'b1;
        bus.enqTag1_i = rtag(); bus.enqTag2_i = rtag(); bus.enqTag3_i = rtag();
        bus.enqVal1_i = rval(); bus.enqVal2_i = rval(); bus.enqVal3_i = rval();
        bus.enqTag_i = 5'($urandom_range(0, 15));
        bus.enqCommands_i = 10'($urandom());
    endtask

    task automatic rand_bus();
        bus.issueROBTagCom_i  = rtag(); bus.issueROBvalCom_i  = rval();
        bus.issueROBTagExec_i = rtag(); bus.issueROBvalExec_i = rval();
        bus.issueROBTagMem_i  = rtag(); bus.issueROBvalMem_i  = rval();
        bus.issueROBMemAccessExec_i = 1'($urandom_range(0, 1));
    endtask

    // One clock of the reference model; call after inputs are set for the cycle
    task automatic tick();
        bit acc, byp;
        model_count = sb.size();
        acc = bus.enq_i && sb.size() != 4 && !bus.needToRestore_i;
        byp = 1'b0;
`ifdef RS_DISPATCH_BYPASS_EN
        byp = sb.size() == 0 && bus.enq_i && !bus.rsStall_i && !bus.needToRestore_i;
`endif
        if (byp) begin
            sb.push_back(incoming());
            acc = 1'b0;
        end
        @(posedge clk);
        foreach (sb[i]) begin
            sb[i].v1 = snoop(sb[i].t1, sb[i].v1);
            sb[i].v2 = snoop(sb[i].t2, sb[i].v2);
            sb[i].v3 = snoop(sb[i].t3, sb[i].v3);
        end
        if (bus.needToRestore_i) sb.delete();
        else if (acc) sb.push_back(incoming());
        @(negedge clk);
    endtask

    // Monitor: status every cycle, entry contents whenever a write is expected
    initial begin
        exp_t e;
        bit   we_exp;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                we_exp = sb.size() != 0 && !bus.rsStall_i && !bus.needToRestore_i;
                chk("write_en", 256'(bus.decodeWriteEn_o), 256'(we_exp));
                chk("count", 256'(bus.count_o), 256'(model_count));
                chk("full", 256'(bus.full_o), 256'(model_count == 4));
                if (we_exp) begin
                    e = sb.pop_front();
                    e.v1 = snoop(e.t1, e.v1);
                    e.v2 = snoop(e.t2, e.v2);
                    e.v3 = snoop(e.t3, e.v3);
                    chk("head_entry",
                        256'({bus.decodeROBTag1_o, bus.decodeROBTag2_o, bus.decodeROBTag3_o,
                              bus.decodeROBTag_o, bus.decodeROBval1_o, bus.decodeROBval2_o,
                              bus.decodeROBval3_o, bus.decodeCommands_o}),
                        256'({e.t1, e.t2, e.t3, e.td, e.v1, e.v2, e.v3, e.cmd}));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.rsStall_i = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_count", 256'(bus.count_o), 256'(0));
        chk("reset_full", 256'(bus.full_o), 256'(0));
        chk("reset_we", 256'(bus.decodeWriteEn_o), 256'(0));
        chk("reset_val1", 256'(bus.decodeROBval1_o), 256'(0));
        chk("reset_dst", 256'(bus.decodeROBTag_o), 256'(0));
        chk("reset_cmd", 256'(bus.decodeCommands_o), 256'(0));
        mon_en = 1'b1;
        tick();

        // Fill under stall; fifth enqueue must be refused
        bus.rsStall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_enq();
            tick();
        end
        idle();
        #1;
        chk("filled_count", 256'(bus.count_o), 256'(4));
        chk("filled_full", 256'(bus.full_o), 256'(1));
        tick();

        // Drain in order
        bus.rsStall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("drain_count", 256'(bus.count_o), 256'(3 - i));
        end

        // Exec forwarding into a waiting operand
        bus.rsStall_i = 1'b1;
        set_enq();
        bus.enqTag1_i = 5'd5;
        bus.enqVal1_i = {1'b0, 64'hA};
        tick();
        idle();
        bus.issueROBTagExec_i = 5'd5;
        bus.issueROBvalExec_i = {1'b1, 64'h123};
        #1;
        chk("exec_forward", 256'(bus.decodeROBval1_o), 256'({1'b1, 64'h123}));
        tick();
        idle();
        bus.rsStall_i = 1'b0;
        tick();

        // Address results from exec are not forwarded
        bus.rsStall_i = 1'b1;
        set_enq();
        bus.enqTag1_i = 5'd5;
        bus.enqVal1_i = {1'b0, 64'hA};
        tick();
        idle();
        bus.issueROBTagExec_i = 5'd5;
        bus.issueROBvalExec_i = {1'b1, 64'h123};
        bus.issueROBMemAccessExec_i = 1'b1;
        #1;
        chk("memaccess_block", 256'(bus.decodeROBval1_o), 256'({1'b0, 64'hA}));
        tick();
        idle();
        bus.rsStall_i = 1'b0;
        tick();

        // Commit wins over mem on the same tag
        bus.rsStall_i = 1'b1;
        set_enq();
        bus.enqTag1_i = 5'd7;
        bus.enqVal1_i = {1'b0, 64'h0};
        tick();
        idle();
        bus.issueROBTagCom_i = 5'd7;
        bus.issueROBvalCom_i = {1'b1, 64'h11};
        bus.issueROBTagMem_i = 5'd7;
        bus.issueROBvalMem_i = {1'b1, 64'h22};
        #1;
        chk("bus_priority", 256'(bus.decodeROBval1_o), 256'({1'b1, 64'h11}));
        tick();
        idle();
        bus.rsStall_i = 1'b0;
        tick();

        // Restore with a simultaneous enqueue drops everything
        bus.rsStall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_enq();
            tick();
        end
        set_enq();
        bus.needToRestore_i = 1'b1;
        tick();
        idle();
        bus.rsStall_i = 1'b0;
        #1;
        chk("restore_count", 256'(bus.count_o), 256'(0));
        chk("restore_we", 256'(bus.decodeWriteEn_o), 256'(0));
        tick();

        // Alternating enqueue/idle across pointer wrap
        for (int i = 0; i < 10; i++) begin
            set_enq();
`ifdef RS_DISPATCH_BYPASS_EN
            #1;
            chk("bypass_we", 256'(bus.decodeWriteEn_o), 256'(1));
`endif
            tick();
            idle();
            #1;
            chk("wrap_count_le1", 256'(bus.count_o <= 3'd1), 256'(1));
            tick();
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            if ($urandom_range(0, 9) < 6) set_enq();
            if ($urandom_range(0, 1) == 0) rand_bus();
            bus.rsStall_i = ($urandom_range(0, 3) == 0);
            bus.needToRestore_i = ($urandom_range(0, 40) == 0);
            tick();
        end

        idle();
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rs_dispatch_queue.md
Name: rs_dispatch_queue

Overview:
- Decode-side producer for the 4-entry forwarding reservation-station cluster. Buffers decoded instructions in a small FIFO.
- While each instruction waits, it snoops the commit, exec and mem result broadcasts. Entries are presented to the cluster's write port only when the cluster is not stalling.
- Waiting operands therefore never miss a broadcast during a dispatch stall.
- Flushed on misprediction restore.

Parameters:
- ROBsize, 16, number of ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), ROB tag width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- needToRestore_i  in  1  flush all entries.
- enq_i  in  1  decode presents an instruction.
- enqTag1_i/enqTag2_i/enqTag3_i  in  ROBsizeLog  source operand tags.
- enqTag_i  in  ROBsizeLog  destination ROB tag.
- enqVal1_i/enqVal2_i/enqVal3_i  in  65  operand: bit64 = ready, [63:0] = data.
- enqCommands_i  in  10  command bits.
- full_o  out  1  queue cannot accept this cycle.
- issueROBTagCom_i, issueROBvalCom_i  in  ROBsizeLog, 65  commit broadcast.
- issueROBTagExec_i, issueROBvalExec_i  in  ROBsizeLog, 65  exec broadcast.
- issueROBMemAccessExec_i  in  1  exec value is an address; do not forward.
- issueROBTagMem_i, issueROBvalMem_i  in  ROBsizeLog, 65  mem broadcast.
- rsStall_i  in  1  the cluster's all-busy stall.
- decodeWriteEn_o  out  1  write to cluster.
- decodeROBTag1_o/2_o/3_o, decodeROBTag_o  out  ROBsizeLog  head tags.
- decodeROBval1_o/2_o/3_o  out  65  head operands.
- decodeCommands_o  out  10  head commands.
- count_o  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Circular FIFO with head pointer, tail pointer and count; pointers wrap modulo DEPTH.
- Reset or needToRestore_i at a clock edge:
  - count, head and tail go to 0.
  - All stored valid bits clear.
- Outputs after reset:
  - decodeWriteEn_o=0, full_o=0, count_o=0.
  - Data outputs 0 (entry storage is reset).
- full_o = (count==DEPTH), combinational.
- Enqueue accepted when enq_i & ~full_o & ~needToRestore_i. Enqueue is refused when full even if a dequeue happens in the same cycle.
- Dequeue:
  - decodeWriteEn_o = (count!=0) & ~rsStall_i & ~needToRestore_i, combinational.
  - A dequeue advances head at the edge.
- Snoop rule, per operand, applied every cycle:
  - If the operand's ready bit is 0 and a bus has val bit64=1 with a tag equal to the operand tag, the operand captures {1, bus data}.
  - The exec bus qualifies only when issueROBMemAccessExec_i=0.
  - Bus priority: commit > mem > exec.
- Snooping applies to:
  - stored entries, updated at the edge;
  - the incoming enqueue operands, so the stored value includes same-cycle broadcasts;
  - the head outputs, combinationally, so the cluster sees a value broadcast in the handoff cycle.
- Latency: an enqueue into an empty queue appears on the outputs on the next cycle. The optional feature changes this.
- Simultaneous enqueue and dequeue with count>0: count is unchanged and both pointers advance.
- Ready operands are never modified, even on a tag match.
- Destination tag and commands pass through unchanged.

Optional Feature:
- RS_DISPATCH_BYPASS_EN defined:
  - When count==0, enq_i=1 and rsStall_i=0, the incoming instruction is driven to the outputs the same cycle with snooping applied.
  - decodeWriteEn_o=1 and nothing is stored (0-cycle latency).
- Undefined: no bypass; minimum latency is 1 cycle.

Decomposition:
- Shared package rs_pkg:
  - OPERAND_W=65, READY_BIT=64, CMD_W=10;
  - typedef rs_operand_t (ready flag plus 64-bit data);
  - typedef rs_dispatch_entry_t (3 tags, 3 operands, destination tag, commands).
- Sub-module rs_operand_snoop: combinational; inputs one operand/tag plus the three buses, output the updated operand. Instantiated 3 per entry, plus 3 for the incoming operands and 3 for the head outputs.

Test Plan:
- Reset, then enqueue 5 back-to-back with rsStall_i=1 → full_o=1 after the 4th, 5th refused, count_o=4, decodeWriteEn_o=0.
- Release stall → 4 consecutive cycles with decodeWriteEn_o=1, in FIFO order; count_o goes 3,2,1,0.
- Enqueue enqVal1_i=65'h0_..._A with enqTag1_i=5 under stall, then issueROBTagExec_i=5, val 65'h1_..._0123, MemAccess=0 → head decodeROBval1_o=65'h1_..._0123. Repeat with MemAccess=1 → stays not-ready.
- Commit and mem both broadcast tag 7 (values ..._11 and ..._22) to a waiting operand → captures ..._11.
- Queue at 3 entries, needToRestore_i pulsed together with enq_i → next cycle count_o=0, no write enable, the incoming instruction is dropped.
- Wrap-around: 10 enqueue/dequeue pairs in alternating cycles → order preserved, count_o ≤1. With RS_DISPATCH_BYPASS_EN, enqueue into an empty queue gives decodeWriteEn_o=1 in the same cycle.
